// File: rtl/led_snake.sv
// 16-LED snake driver: a band of switch+1 lit LEDs rotates toward the MSB while
// the button is held; the fill term lets the band grow or shrink after a switch change.
module led_snake (
    input  logic        clk,
    input  logic        rst,
    input  logic        button,
    input  logic [2:0]  switch,
    output logic [15:0] led
);

    logic [7:0]  length;
    logic        fill;
    logic [15:0] led_p0;

    // All-ones mask of switch+1 bits; switch=7 yields 0xFF without overflow.
    function automatic logic [7:0] band_length(input logic [2:0] sel);
        logic [8:0] ones;
        ones = (9'd1 << ({6'd0, sel} + 9'd1)) - 9'd1;
        return ones[7:0];
    endfunction

    function automatic logic calc_fill(input logic [15:0] cur, input logic [7:0] len);
        return (cur[15] | cur[0]) & (cur[7:0] < len);
    endfunction

    always_comb begin
        length = band_length(switch);
        fill   = calc_fill(led_p0, length);
    end

    // Stage 0: the LED register itself; reset outranks the step enable.
    always_ff @(posedge clk) begin
        if (rst) begin
            led_p0 <= {8'h00, length};
        end else if (button) begin
            led_p0 <= {led_p0[14:0], fill};
        end
    end

    assign led = led_p0;

endmodule

// File: tb/tb_led_snake.sv
// Bench for led_snake: directed scenarios followed by random traffic, all checked
// against an arithmetic model of the band's rotate/grow/shrink rules.
module tb_led_snake;

    logic        clk;
    logic        rst;
    logic        button;
    logic [2:0]  switch;
    logic [15:0] led;

    int checks;
    int errors;
    int model_led;

    led_snake dut (
        .clk    (clk),
        .rst    (rst),
        .button (button),
        .switch (switch),
        .led    (led)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Band length as a count of lit LEDs turned into a value: 2^(n) - 1, n = sw+1.
    function automatic int ref_length(input int sw);
        return (2 ** (sw + 1)) - 1;
    endfunction

    function automatic int ref_next(input int cur, input int r, input int b, input int sw);
        int top, bottom, low_byte, f;
        if (r != 0) return ref_length(sw);
        if (b == 0) return cur;
        top      = (cur / 32768) % 2;
        bottom   = cur % 2;
        low_byte = cur % 256;
        f        = ((top == 1 || bottom == 1) && (low_byte < ref_length(sw))) ? 1 : 0;
        return ((cur * 2) % 65536) + f;
    endfunction

    task automatic check(input string tag, input int exp);
        logic [15:0] e;
        e = exp[15:0];
        checks++;
        assert (led === e) else begin
            errors++;
            $error("FAIL %s: led=%h expected=%h", tag, led, e);
        end
    endtask

    task automatic cycle(input logic r, input logic b, input logic [2:0] s, input string tag);
        @(negedge clk);
        rst    = r;
        button = b;
        switch = s;
        @(posedge clk);
        model_led = ref_next(model_led, int'(r), int'(b), int'(s));
        #1;
        check(tag, model_led);
    endtask

    initial begin : stim
        logic [15:0] ring [16];
        logic        r, b;
        logic [2:0]  s;

        ring = '{16'h000E, 16'h001C, 16'h0038, 16'h0070, 16'h00E0, 16'h01C0,
                 16'h0380, 16'h0700, 16'h0E00, 16'h1C00, 16'h3800, 16'h7000,
                 16'hE000, 16'hC001, 16'h8003, 16'h0007};
        checks    = 0;
        errors    = 0;
        model_led = 0;
        rst       = 1'b0;
        button    = 1'b0;
        switch    = 3'd0;

        // Full rotation with a 3-LED band.
        cycle(1'b1, 1'b0, 3'd2, "reset_sw2");
        check("reset_sw2_const", 16'h0007);
        for (int i = 0; i < 16; i++) begin
            cycle(1'b0, 1'b1, 3'd2, "rotate");
            check("rotate_const", int'(ring[i]));
        end

        // Extreme band lengths.
        cycle(1'b1, 1'b0, 3'd0, "reset_sw0");
        check("reset_sw0_const", 16'h0001);
        cycle(1'b1, 1'b0, 3'd7, "reset_sw7");
        check("reset_sw7_const", 16'h00FF);
        cycle(1'b0, 1'b1, 3'd7, "step_sw7");
        check("step_sw7_const", 16'h01FE);

        // Hold with the button released.
        cycle(1'b1, 1'b0, 3'd2, "reset_hold");
        cycle(1'b0, 1'b1, 3'd2, "pre_hold1");
        cycle(1'b0, 1'b1, 3'd2, "pre_hold2");
        check("pre_hold_const", 16'h001C);
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, 1'b0, 3'd2, "hold");
            check("hold_const", 16'h001C);
        end
        cycle(1'b0, 1'b1, 3'd2, "resume");
        check("resume_const", 16'h0038);

        // Reset pulse between edges must be ignored.
        @(negedge clk);
        button = 1'b0;
        #1 rst = 1'b1;
        #2 rst = 1'b0;
        @(posedge clk);
        #1;
        check("rst_glitch", model_led);
        check("rst_glitch_const", 16'h0038);
        cycle(1'b1, 1'b1, 3'd2, "rst_over_button");
        check("rst_over_button_const", 16'h0007);

        // Band growth after widening the switch.
        cycle(1'b1, 1'b0, 3'd0, "grow_reset");
        cycle(1'b0, 1'b1, 3'd2, "grow1");
        check("grow1_const", 16'h0003);
        cycle(1'b0, 1'b1, 3'd2, "grow2");
        check("grow2_const", 16'h0007);
        cycle(1'b0, 1'b1, 3'd2, "grow3");
        check("grow3_const", 16'h000E);

        // Band shrink after narrowing the switch.
        cycle(1'b1, 1'b0, 3'd2, "shrink_reset");
        for (int i = 0; i < 15; i++) cycle(1'b0, 1'b1, 3'd2, "shrink_walk");
        check("shrink_walk_const", 16'h8003);
        cycle(1'b0, 1'b1, 3'd0, "shrink1");
        check("shrink1_const", 16'h0006);
        cycle(1'b0, 1'b1, 3'd0, "shrink2");
        check("shrink2_const", 16'h000C);

        // Random traffic with occasional resets and switch changes.
        s = 3'($urandom_range(0, 7));
        cycle(1'b1, 1'b0, s, "rand_reset");
        for (int i = 0; i < 400; i++) begin
            r = ($urandom_range(0, 19) == 0);
            b = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 7) == 0) s = 3'($urandom_range(0, 7));
            cycle(r, b, s, "random");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
